// File: rtl/sprite_color_reader.sv
// Sprite RAM colour fetch for the sprite selector: 2-cycle latency, one pixel per clock, no backpressure.
// Optional SPRITE_TRANSPARENCY_EN: a hit on a KEY_COLOR word emits BG_COLOR instead.
module sprite_color_reader #(
  parameter int ELEMENT = 5,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_SPRITES = 8,
  parameter int COLOR_WIDTH = 9,
  parameter logic [COLOR_WIDTH-1:0] BG_COLOR = 9'h000,
  parameter logic [COLOR_WIDTH-1:0] KEY_COLOR = 9'h1C7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ready,
  input  logic [ELEMENT-1:0]     element,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic                   active,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   wr_en,
  input  logic [ELEMENT-1:0]     wr_element,
  input  logic [ADDR_WIDTH-1:0]  wr_address,
  input  logic [COLOR_WIDTH-1:0] wr_data,
  output logic                   wr_err,
  output logic [2:0]             red,
  output logic [2:0]             green,
  output logic [2:0]             blue,
  output logic                   de,
  output logic                   hsync_out,
  output logic                   vsync_out
);

  localparam int SLOT_BITS = $clog2(NUM_SPRITES);
  localparam int RAM_AW = SLOT_BITS + ADDR_WIDTH;
  localparam int RAM_DEPTH = 1 << RAM_AW;
  localparam logic [ELEMENT-1:0] SLOT_LIMIT = ELEMENT'(NUM_SPRITES);

  logic [COLOR_WIDTH-1:0] spriteRam [0:RAM_DEPTH-1];
  logic [COLOR_WIDTH-1:0] rdData;

  logic              hit;
  logic              wrOk;
  logic [RAM_AW-1:0] rdAddr;
  logic [RAM_AW-1:0] wrAddr;

  logic hitS1;
  logic activeS1;
  logic hsyncS1;
  logic vsyncS1;

  logic                   isKey;
  logic [COLOR_WIDTH-1:0] pixColor;

  assign hit    = ready & active & (element != '0) & (element < SLOT_LIMIT);
  assign wrOk   = wr_en & (wr_element != '0) & (wr_element < SLOT_LIMIT);
  assign rdAddr = {element[SLOT_BITS-1:0], address};
  assign wrAddr = {wr_element[SLOT_BITS-1:0], wr_address};

  // Read and write share one block so a same-word collision returns the old word.
  always_ff @(posedge clk) begin
    if (wrOk) begin
      spriteRam[wrAddr] <= wr_data;
    end
    rdData <= spriteRam[rdAddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hitS1    <= 1'b0;
      activeS1 <= 1'b0;
      hsyncS1  <= 1'b1;
      vsyncS1  <= 1'b1;
      wr_err   <= 1'b0;
    end else begin
      hitS1    <= hit;
      activeS1 <= active;
      hsyncS1  <= hsync_in;
      vsyncS1  <= vsync_in;
      wr_err   <= wr_en & ~wrOk;
    end
  end

`ifdef SPRITE_TRANSPARENCY_EN
  assign isKey = (rdData == KEY_COLOR);
`else
  logic unusedKeyColor;
  assign unusedKeyColor = ^KEY_COLOR;
  assign isKey = 1'b0;
`endif

  always_comb begin
    pixColor = '0;
    if (activeS1) begin
      pixColor = (hitS1 && !isKey) ? rdData : BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      de        <= 1'b0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      red       <= pixColor[8:6];
      green     <= pixColor[5:3];
      blue      <= pixColor[2:0];
      de        <= activeS1;
      hsync_out <= hsyncS1;
      vsync_out <= vsyncS1;
    end
  end

endmodule

// File: tb/tb_sprite_color_reader.sv
// Directed bench for sprite_color_reader: vector table plus hand-written collision, sync and reset sequences.
module tb_sprite_color_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       ready;
  logic [4:0] element;
  logic [9:0] address;
  logic       active;
  logic       hsync_in;
  logic       vsync_in;
  logic       wr_en;
  logic [4:0] wr_element;
  logic [9:0] wr_address;
  logic [8:0] wr_data;
  logic       wr_err;
  logic [2:0] red, green, blue;
  logic       de, hsync_out, vsync_out;

  int errors = 0;
  int checks = 0;

  sprite_color_reader dut (
    .clk(clk), .reset(reset), .ready(ready), .element(element), .address(address),
    .active(active), .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_en(wr_en),
    .wr_element(wr_element), .wr_address(wr_address), .wr_data(wr_data), .wr_err(wr_err),
    .red(red), .green(green), .blue(blue), .de(de), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

`ifdef SPRITE_TRANSPARENCY_EN
  localparam logic [8:0] KEY_EXP = 9'h000;
`else
  localparam logic [8:0] KEY_EXP = 9'h1C7;
`endif

  typedef struct {
    string      name;
    logic       rdy;
    logic [4:0] el;
    logic [9:0] ad;
    logic       act;
    logic       hs;
    logic       vs;
    logic [8:0] rgb;
    logic       de;
  } vec_t;

  vec_t tbl[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Packed outputs: {rgb[8:0], de, hsync_out, vsync_out, wr_err}
  task automatic chk(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = {red, green, blue, de, hsync_out, vsync_out, wr_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rgb=%h de=%b hs=%b vs=%b err=%b, want rgb=%h de=%b hs=%b vs=%b err=%b",
               name, act[12:4], act[3], act[2], act[1], act[0],
               exp[12:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic chkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic setRead(input logic rdy, input logic [4:0] el, input logic [9:0] ad,
                         input logic act, input logic hs, input logic vs);
    ready = rdy; element = el; address = ad; active = act; hsync_in = hs; vsync_in = vs;
  endtask

  task automatic writeWord(input logic [4:0] el, input logic [9:0] ad, input logic [8:0] d);
    wr_en = 1'b1; wr_element = el; wr_address = ad; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    int hsLow;
    int firstLow;
    logic [8:0] expColor;
    logic       expHs;

    reset = 1'b1;
    wr_en = 1'b0; wr_element = '0; wr_address = '0; wr_data = '0;
    setRead(1'b0, 5'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("reset_values", {9'h000, 1'b0, 1'b1, 1'b1, 1'b0});
    tick();
    reset = 1'b0;

    writeWord(5'd1, 10'd0, 9'h1F8);
    writeWord(5'd2, 10'd5, 9'h007);
    writeWord(5'd3, 10'd10, 9'h1C7);
    writeWord(5'd4, 10'd3, 9'h0AB);
    writeWord(5'd7, 10'd1023, 9'h155);
    chkBit("wr_err_valid_write", wr_err, 1'b0);

    tbl.push_back('{"load_read",     1'b1, 5'd1, 10'd0,    1'b1, 1'b1, 1'b1, 9'h1F8, 1'b1});
    tbl.push_back('{"miss_ready0",   1'b0, 5'd1, 10'd0,    1'b1, 1'b1, 1'b1, 9'h000, 1'b1});
    tbl.push_back('{"reserved_el0",  1'b1, 5'd0, 10'd0,    1'b1, 1'b1, 1'b1, 9'h000, 1'b1});
    tbl.push_back('{"inactive",      1'b1, 5'd1, 10'd0,    1'b0, 1'b1, 1'b1, 9'h000, 1'b0});
    tbl.push_back('{"out_of_range8", 1'b1, 5'd8, 10'd0,    1'b1, 1'b1, 1'b1, 9'h000, 1'b1});
    tbl.push_back('{"out_of_range31",1'b1, 5'd31, 10'd0,   1'b1, 1'b1, 1'b1, 9'h000, 1'b1});
    tbl.push_back('{"last_slot_word",1'b1, 5'd7, 10'd1023, 1'b1, 1'b1, 1'b1, 9'h155, 1'b1});
    tbl.push_back('{"transparency",  1'b1, 5'd3, 10'd10,   1'b1, 1'b1, 1'b1, KEY_EXP, 1'b1});
    tbl.push_back('{"slot4_syncs",   1'b1, 5'd4, 10'd3,    1'b1, 1'b0, 1'b0, 9'h0AB, 1'b1});
    tbl.push_back('{"vsync_only",    1'b1, 5'd2, 10'd5,    1'b1, 1'b1, 1'b0, 9'h007, 1'b1});
    tbl.push_back('{"blank_hsync",   1'b0, 5'd0, 10'd0,    1'b0, 1'b0, 1'b1, 9'h000, 1'b0});

    foreach (tbl[i]) begin
      setRead(tbl[i].rdy, tbl[i].el, tbl[i].ad, tbl[i].act, tbl[i].hs, tbl[i].vs);
      tick();
      tick();
      chk(tbl[i].name, {tbl[i].rgb, tbl[i].de, tbl[i].hs, tbl[i].vs, 1'b0});
    end

    // Rejected writes: slot 9 aliases slot 1 after truncation, slot 0 is reserved.
    setRead(1'b1, 5'd1, 10'd0, 1'b1, 1'b1, 1'b1);
    writeWord(5'd9, 10'd0, 9'h0AA);
    chkBit("wr_err_slot9", wr_err, 1'b1);
    tick();
    chkBit("wr_err_one_cycle", wr_err, 1'b0);
    writeWord(5'd0, 10'd0, 9'h0AA);
    chkBit("wr_err_slot0", wr_err, 1'b1);
    tick();
    tick();
    chk("alias_unchanged", {9'h1F8, 1'b1, 1'b1, 1'b1, 1'b0});

    // Same-word read and write in one cycle: old word first, new word next.
    setRead(1'b1, 5'd2, 10'd5, 1'b1, 1'b1, 1'b1);
    writeWord(5'd2, 10'd5, 9'h038);
    tick();
    chk("collision_old", {9'h007, 1'b1, 1'b1, 1'b1, 1'b0});
    tick();
    chk("collision_new", {9'h038, 1'b1, 1'b1, 1'b1, 1'b0});

    // Sync alignment: 96-cycle hsync pulse with a different colour every pixel.
    for (int c = 0; c < 120; c++) writeWord(5'd5, 10'(c), 9'((c * 37) % 512));
    hsLow = 0;
    firstLow = -1;
    for (int c = 0; c < 121; c++) begin
      if (c < 120) setRead(1'b1, 5'd5, 10'(c), 1'b1, !(c >= 10 && c < 106), 1'b1);
      else setRead(1'b0, 5'd0, 10'd0, 1'b0, 1'b1, 1'b1);
      tick();
      if (c >= 1) begin
        expColor = 9'(((c - 1) * 37) % 512);
        expHs = !((c - 1) >= 10 && (c - 1) < 106);
        chk("sync_px", {expColor, 1'b1, expHs, 1'b1, 1'b0});
        if (!hsync_out) begin
          hsLow++;
          if (firstLow < 0) firstLow = c - 1;
        end
      end
    end
    checks++;
    if (hsLow != 96) begin
      errors++;
      $display("FAIL hsync_low_len: got %0d want 96", hsLow);
    end
    checks++;
    if (firstLow != 10) begin
      errors++;
      $display("FAIL hsync_start: got %0d want 10", firstLow);
    end

    // Reset in the middle of streaming.
    setRead(1'b1, 5'd1, 10'd0, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    chk("stream_before_reset", {9'h1F8, 1'b1, 1'b0, 1'b1, 1'b0});
    reset = 1'b1;
    tick();
    chk("mid_reset", {9'h000, 1'b0, 1'b1, 1'b1, 1'b0});
    reset = 1'b0;
    tick();
    chk("after_reset_1", {9'h000, 1'b0, 1'b1, 1'b1, 1'b0});
    tick();
    chk("after_reset_2", {9'h1F8, 1'b1, 1'b0, 1'b1, 1'b0});
    setRead(1'b1, 5'd4, 10'd3, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    chk("ram_kept", {9'h0AB, 1'b1, 1'b1, 1'b1, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_color_reader.md
# sprite_color_reader

Reads the sprite memory on behalf of the sprite priority selector. Each cycle it takes the selector's `ready`/`element`/`address` triple and fetches the 9-bit colour word from an internal dual-port sprite RAM. It drives the VGA RGB and sync outputs, with the syncs delayed so that pixel data and sync stay aligned. A separate write port loads sprite bitmaps from the game controller.

## Interface
- `ELEMENT`, 5: width of the element index input.
- `ADDR_WIDTH`, 10: words-per-sprite address width; each sprite occupies 2^ADDR_WIDTH words.
- `NUM_SPRITES`, 8: number of sprite slots stored. Element values 1..NUM_SPRITES-1 are legal; element 0 is reserved and not stored.
- `COLOR_WIDTH`, 9: colour word width, 3 bits each for R, G, B (MSBs = R).
- `BG_COLOR`, 9'h000: colour emitted when no sprite covers the pixel.
- `KEY_COLOR`, 9'h1C7: transparency key (magenta).

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: synchronous, active-high.
- `ready` in 1: selector reports that a sprite covers the current pixel.
- `element` in ELEMENT: sprite slot index.
- `address` in ADDR_WIDTH: word offset inside the sprite.
- `active` in 1: video-enable for the current pixel.
- `hsync_in` in 1: horizontal sync, active low.
- `vsync_in` in 1: vertical sync, active low.
- `wr_en` in 1: write strobe, one word per cycle.
- `wr_element` in ELEMENT: slot to write.
- `wr_address` in ADDR_WIDTH: word to write.
- `wr_data` in COLOR_WIDTH: colour to write.
- `wr_err` out 1: one-cycle pulse for a rejected write.
- `red`, `green`, `blue` out 3 each: pixel colour.
- `de` out 1: delayed active.
- `hsync_out` out 1: delayed hsync_in.
- `vsync_out` out 1: delayed vsync_in.

## Operation
- **Input sampling:** inputs are sampled on posedge clk. The selector updates on negedge, so inputs are stable at posedge.
- **Stage 1 (S1):** compute `hit = ready & active & (element != 0) & (element < NUM_SPRITES)`.
  - Register `hit`, `active`, and both syncs.
  - Issue the RAM read at `{element, address}`, truncated to log2(NUM_SPRITES)+ADDR_WIDTH bits.
- **Stage 2 (S2):** the RAM data word is valid.
  - Colour = RAM word if the S1 hit is set, else BG_COLOR.
  - Outputs are forced to 0 when the S1 active is clear.
  - Register the colour to the outputs along with de and the syncs.
- **Write port:** a write occurs at posedge when `wr_en` is set and `wr_element` is in 1..NUM_SPRITES-1.
  - Otherwise `wr_err` pulses in the following cycle and the RAM is unchanged.
  - Writes are permitted during active video.
- **Read/write collision:** a read and a write to the same word in the same cycle return the old data (read-before-write). The new data is visible on the next read.
- **Reset:** reset does not clear the RAM. It clears only pipeline and output state.

## Timing
- **Latency:** 2 cycles from input sampling to `red/green/blue/de`. Syncs are delayed by exactly 2 cycles, so alignment with colour is preserved.
- **Throughput:** one pixel per clock, no stalls, no backpressure.
- **Reset values:**
  - `red`, `green`, `blue` = 0.
  - `de` = 0.
  - `hsync_out` = 1, `vsync_out` = 1 (inactive).
  - `wr_err` = 0.
  - All pipeline valid bits cleared.
- **Reset mid-line:** any in-flight pixels are discarded. The first valid output appears 2 cycles after reset deasserts with valid input.
- **Out-of-range or zero element with `ready`:** treated as a miss and emits BG_COLOR. No error output.
- **`ready` set with `active` clear:** output is black, `de` = 0.

## Configuration
- `SPRITE_TRANSPARENCY_EN`:
  - **Defined:** at S2, a hit whose RAM word equals KEY_COLOR emits BG_COLOR instead of the key.
  - **Undefined:** KEY_COLOR is emitted literally like any other colour. The KEY_COLOR comparator is not synthesized.

## Test plan
- **Load and read:** write 9'h1F8 to slot 1, word 0, then drive `ready`=1, `element`=1, `address`=0, `active`=1 → 2 cycles later `red`=7, `green`=7, `blue`=0, `de`=1.
- **Miss and reserved slot:**
  - `ready`=0 with `active`=1 → outputs BG_COLOR (0,0,0) with `de`=1.
  - `element`=0 with `ready`=1 → same.
- **Write rejection and collision:**
  - Write to slot 9 (NUM_SPRITES=8) → `wr_err`=1 for one cycle; a read of the aliased address is unchanged.
  - Same-cycle write and read of slot 2, word 5 (old 9'h007, new 9'h038) → first read returns 9'h007, next read returns 9'h038.
- **Transparency:** slot 3, word 10 holds 9'h1C7.
  - With `SPRITE_TRANSPARENCY_EN` defined → output 0,0,0.
  - Without it → `red`=7, `green`=0, `blue`=7.
- **Sync alignment:** drive an hsync_in low pulse of 96 cycles with colour stepping each cycle → `hsync_out` low for exactly 96 cycles, starting 2 cycles later, with colour aligned pixel-for-pixel.
- **Reset mid-frame:** assert `reset` for 1 cycle during streaming → next cycle all outputs are at reset values; correct data resumes 2 cycles after release; RAM contents are preserved.
